// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared types for the prefetching instruction-fetch unit:
// fetch state encoding, default reset PC and the prefetch entry layout.
package ysyx_25030093_ifu_pkg;

    // Fetch control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for FIFO room
        REQ  = 2'd1,   // request presented on the memory port
        WAIT = 2'd2,   // request accepted, waiting for the beat
        HALT = 2'd3    // fault fetched, parked until redirect
    } ifu_state_e;

    // Default fetch address after reset
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Default-width entry layout; the top packs its FIFO word in this order
    localparam int IFU_ADDR_W = 32;
    localparam int IFU_INST_W = 32;

    typedef struct packed {
        logic [IFU_INST_W-1:0] inst;
        logic [IFU_ADDR_W-1:0] pc;
        logic                  err;
    } ifu_entry_t;

endpackage

// File: rtl/ysyx_25030093_ifu_fifo.sv
// Synchronous prefetch FIFO with flush and occupancy count.
// Output word reads as zero while empty so the consumer never sees stale data.
module ysyx_25030093_ifu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Flush overrides both push and pop in the same cycle
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    // Next pointer / occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
            if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o    = (count_q != '0);
    assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/ysyx_25030093_ifu_prefetch.sv
// Instruction-fetch unit with prefetch FIFO.
// Issues one sequential fetch at a time, buffers {inst, pc, err} and
// hands entries to IDU; redirect flushes and drops any in-flight beat.
// Optional performance counters: define YSYX_IFU_PERF_CNT_EN.
module ysyx_25030093_ifu_prefetch
    import ysyx_25030093_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_err
`ifdef YSYX_IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt,
    output logic [31:0]       perf_full_cyc
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam int               ENT_W   = INST_W + ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic              push, pop, room;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  push_data, pop_data;

    // Room must also cover the single outstanding request
    assign room         = (fifo_count < DEPTH_C);
    assign mem_req_addr = req_pc_q;
    assign push_data    = {mem_rsp_data, req_pc_q, mem_rsp_err};
    assign pop          = out_valid & out_ready;

    // Fetch sequencing; redirect is applied last so it wins over everything
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        drop_d        = drop_q;
        mem_req_valid = 1'b0;
        push          = 1'b0;
        case (state_q)
            IDLE: begin
                if (room) begin
                    state_d  = REQ;
                    req_pc_d = fetch_pc_q;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                    // After a redirect fetch_pc already holds the new target
                    if (!drop_q) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = mem_rsp_err ? HALT : IDLE;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            push       = 1'b0;
            case (state_q)
                // Request stays on the bus with the old address; its beat is dropped
                REQ: drop_d = 1'b1;
                WAIT: begin
                    if (mem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
        end
    end

    ysyx_25030093_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .valid_o     (out_valid),
        .count_o     (fifo_count)
    );

    assign {out_inst, out_pc, out_err} = pop_data;

`ifdef YSYX_IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q, full_cyc_q;
    logic        rsp_discard;

    assign rsp_discard = (state_q == WAIT) && mem_rsp_valid && (drop_q || redirect_valid);

    // Event counters, free-running with natural wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
            full_cyc_q  <= '0;
        end else begin
            if (push)                       fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (rsp_discard)                drop_cnt_q  <= drop_cnt_q + 32'd1;
            if ((state_q == IDLE) && !room) full_cyc_q  <= full_cyc_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;
    assign perf_full_cyc  = full_cyc_q;
`endif

endmodule

// File: tb/tb_ysyx_25030093_ifu_prefetch.sv
// Scoreboard bench for the prefetching IFU: memory model, IDU model,
// decoupled monitor, directed scenarios then randomized redirects/resets.
`timescale 1ns/1ps
module tb_ysyx_25030093_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
`ifdef YSYX_IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_full_cyc;
`endif

    always #5 clk = ~clk;

    ysyx_25030093_ifu_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_err        (out_err)
`ifdef YSYX_IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt),
        .perf_full_cyc  (perf_full_cyc)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] acc_q[$];
    int          req_cyc = 0;
    int          mem_mode = 0;   // 0 ready, 1 not ready, 2 random
    int          idu_mode = 0;   // 0 ready, 1 not ready, 2 random
    int          lat_min = 0;
    int          lat_max = 0;
    bit          err_en = 1'b0;
    logic [31:0] err_pc = 32'h0;

    // Contents of instruction memory
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
        return err_en && (a == err_pc);
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        if (i >= 0 && i < acc_q.size()) return acc_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        check(act === req, name, act, req);
    endtask

    // Expected stream after a (re)start: sequential PCs, ending at the first fault
    task automatic refill(input logic [31:0] base);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < 256; k++) begin
            e.pc   = base + 32'(4 * k);
            e.inst = inst_of(e.pc);
            e.err  = err_of(e.pc);
            exp_q.push_back(e);
            if (e.err) break;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; leaves at posedge+1 after the redirect cycle
    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        refill(pc);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        refill(RST_PC);
    endtask

    // Memory: accepts requests, answers after lat cycles, abandons on reset
    initial begin : mem_model
        bit          hs, pend;
        logic [31:0] hs_addr, pend_addr;
        int          dly;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        pend = 1'b0; dly = 0; pend_addr = '0;
        forever begin
            @(negedge clk);
            hs      = !rst && mem_req_valid && mem_req_ready;
            hs_addr = mem_req_addr;
            @(posedge clk);
            #2;
            mem_rsp_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    check(!pend, "one_outstanding", 32'(pend), 32'd0);
                    pend      = 1'b1;
                    pend_addr = hs_addr;
                    acc_q.push_back(hs_addr);
                    dly       = $urandom_range(lat_max, lat_min);
                end
                if (pend) begin
                    if (dly == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = inst_of(pend_addr);
                        mem_rsp_err   = err_of(pend_addr);
                        pend          = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
            case (mem_mode)
                0:       mem_req_ready = 1'b1;
                1:       mem_req_ready = 1'b0;
                default: mem_req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // IDU back-pressure
    initial begin : idu_model
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (idu_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks handshake rules
    initial begin : monitor
        bit          p_ov, p_or, p_rv, p_rr, p_redir, p_rst;
        logic [31:0] p_inst, p_pc, p_addr;
        logic        p_err;
        exp_t        e;
        p_ov = 0; p_or = 0; p_rv = 0; p_rr = 0; p_redir = 0; p_rst = 1;
        p_inst = '0; p_pc = '0; p_addr = '0; p_err = 0;
        forever begin
            @(negedge clk);
            if (!rst && !p_rst) begin
                if (p_redir)
                    check_eq("out_valid_after_redirect", 32'(out_valid), 32'd0);
                else if (p_ov && !p_or)
                    check(out_valid && out_pc == p_pc && out_inst == p_inst && out_err == p_err,
                          "out_stable", out_pc, p_pc);
                if (p_rv && !p_rr)
                    check(mem_req_valid && mem_req_addr == p_addr, "req_addr_stable", mem_req_addr, p_addr);
                if (out_valid && out_ready) begin
                    check(exp_q.size() > 0, "output_expected", out_pc, 32'(exp_q.size()));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("out_pc", out_pc, e.pc);
                        check_eq("out_inst", out_inst, e.inst);
                        check_eq("out_err", 32'(out_err), 32'(e.err));
                    end
                end
                if (mem_req_valid) req_cyc++;
            end
            p_ov = out_valid; p_or = out_ready; p_inst = out_inst; p_pc = out_pc; p_err = out_err;
            p_rv = mem_req_valid; p_rr = mem_req_ready; p_addr = mem_req_addr;
            p_redir = redirect_valid; p_rst = rst;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          idx, idx0, r0;
        bit          ok;
        logic [31:0] a, t;
`ifdef YSYX_IFU_PERF_CNT_EN
        logic [31:0] drop0;
`endif
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_inst", out_inst, 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
`ifdef YSYX_IFU_PERF_CNT_EN
        check_eq("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check_eq("rst_perf_drop", perf_drop_cnt, 32'd0);
        check_eq("rst_perf_full", perf_full_cyc, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        refill(RST_PC);
        @(negedge clk);
        check_eq("req_before_first_edge", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        check_eq("first_req_valid", 32'(mem_req_valid), 32'd1);
        check_eq("first_req_addr", mem_req_addr, RST_PC);
        @(posedge clk); #1;

        // Sequential fetch with zero-wait memory
        cyc(30);
        check_eq("seq_addr0", acc_at(0), 32'h8000_0000);
        check_eq("seq_addr1", acc_at(1), 32'h8000_0004);
        check_eq("seq_addr2", acc_at(2), 32'h8000_0008);

        // Reset mid-stream, then fill with IDU stalled
        idu_mode = 1;
        do_reset();
        idx0 = acc_q.size();
        cyc(40);
        @(negedge clk);
        check_eq("fill_req_count", 32'(acc_q.size() - idx0), 32'd4);
        check_eq("fill_no_5th_req", 32'(mem_req_valid), 32'd0);
        check_eq("fill_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        idu_mode = 0;
        cyc(30);
        check_eq("fill_first_addr", acc_at(idx0), RST_PC);
        check_eq("fill_resume_addr", acc_at(idx0 + 4), 32'h8000_0010);

        // Redirect while waiting for a slow beat
        lat_min = 3; lat_max = 3;
        cyc(1);
        ok = 1'b0; idx = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin ok = 1'b1; break; end
        end
        check(ok, "wait_handshake", 32'(ok), 32'd1);
        idx = acc_q.size() + 1;
`ifdef YSYX_IFU_PERF_CNT_EN
        drop0 = perf_drop_cnt;
`endif
        @(posedge clk); #1;
        do_redirect(32'h8000_0100);
        lat_min = 0; lat_max = 0;
        cyc(25);
        check_eq("wait_redirect_next_addr", acc_at(idx), 32'h8000_0100);
`ifdef YSYX_IFU_PERF_CNT_EN
        check_eq("wait_redirect_drop_cnt", perf_drop_cnt - drop0, 32'd1);
`endif

        // Redirect while the request is stalled on the memory port
        mem_mode = 1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_req_valid && !mem_req_ready) begin ok = 1'b1; break; end
        end
        check(ok, "stalled_request", 32'(ok), 32'd1);
        a   = mem_req_addr;
        idx = acc_q.size();
        @(posedge clk); #1;
        do_redirect(32'h8000_0200);
        repeat (3) begin
            @(negedge clk);
            check(mem_req_valid && mem_req_addr == a, "req_held_after_redirect", mem_req_addr, a);
        end
        @(posedge clk); #1;
        mem_mode = 0;
        cyc(25);
        check_eq("req_redirect_old_addr", acc_at(idx), a);
        check_eq("req_redirect_new_addr", acc_at(idx + 1), 32'h8000_0200);

        // Fault on the second fetch halts the unit
        err_pc = 32'h8000_0304; err_en = 1'b1;
        do_redirect(32'h8000_0300);
        cyc(40);
        check_eq("err_stream_consumed", 32'(exp_q.size()), 32'd0);
        idx = acc_q.size();
        r0  = req_cyc;
        cyc(20);
        check_eq("halt_no_accept", 32'(acc_q.size()), 32'(idx));
        check_eq("halt_no_req_valid", 32'(req_cyc - r0), 32'd0);

        // Address wrap-around
        err_en = 1'b0;
        do_redirect(32'hFFFF_FFFC);
        cyc(30);
        check_eq("wrap_addr0", acc_at(idx), 32'hFFFF_FFFC);
        check_eq("wrap_addr1", acc_at(idx + 1), 32'h0000_0000);

        // Randomized back-pressure, latency, redirects, faults and resets
        mem_mode = 2; idu_mode = 2;
        repeat (60) begin
            lat_max = $urandom_range(0, 3);
            cyc($urandom_range(3, 40));
            if ($urandom_range(0, 9) == 0) begin
                err_en = 1'b0;
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                else                           t = $urandom() & 32'hFFFF_FFFC;
                err_en = ($urandom_range(0, 2) == 0);
                err_pc = t + 32'(4 * $urandom_range(0, 6));
                do_redirect(t);
            end
        end
        mem_mode = 0; idu_mode = 0;
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_ifu_prefetch.md
# ysyx_25030093_ifu_prefetch

Parametrised instruction-fetch unit with a prefetch FIFO, replacing the single-beat fetch-SRAM front end. Issues sequential fetch requests on a valid/ready memory port, buffers returned instructions with their PC, and hands them to IDU on a valid/ready output. Supports redirect (branch/trap) with flush and discard of in-flight responses, and halts on fetch error.

## Interface
Parameters:
- `ADDR_W`, 32, PC/address width
- `INST_W`, 32, instruction width
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2
- `RESET_PC`, 32'h8000_0000, fetch address after reset

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1 clock
- `rst` in 1 async active-high reset
- `redirect_valid` in 1 flush and restart fetch
- `redirect_pc` in ADDR_W new fetch PC
- `mem_req_valid` out 1 fetch request
- `mem_req_ready` in 1 memory accepts request
- `mem_req_addr` out ADDR_W fetch address
- `mem_rsp_valid` in 1 response beat (always accepted)
- `mem_rsp_data` in INST_W fetched instruction
- `mem_rsp_err` in 1 access fault
- `out_valid` out 1 instruction available
- `out_ready` in 1 IDU accepts
- `out_inst` out INST_W instruction
- `out_pc` out ADDR_W PC of `out_inst`
- `out_err` out 1 entry carries fault

## Operation
- State machine `IDLE`, `REQ`, `WAIT`, `HALT`; plus `drop` flag register.
- `IDLE`: if `count + 1 ≤ DEPTH` (room incl. one outstanding) → `REQ`. Otherwise stay.
- `REQ`: `mem_req_valid=1`, `mem_req_addr=fetch_pc`; addr held stable until `mem_req_ready`; on handshake → `WAIT`, latch `req_pc=fetch_pc`, `fetch_pc += 4` (mod 2^ADDR_W, wrap-around allowed).
- `WAIT`: on `mem_rsp_valid`: if `drop` → clear `drop`, discard; else push {data, req_pc, err}. Then → `HALT` if err pushed, else `IDLE`.
- `HALT`: no requests until redirect.
- Max one outstanding request.
- Redirect (highest priority): FIFO emptied, `fetch_pc=redirect_pc`; from `IDLE`/`HALT` → `IDLE`; from `REQ` → stays `REQ` holding old addr, sets `drop`, next request after that response uses `redirect_pc`; from `WAIT` → sets `drop` unless `mem_rsp_valid` same cycle (that beat discarded, → `IDLE`).
- Output pop on `out_valid & out_ready`; simultaneous push+pop when full not possible (room check includes outstanding).

## Timing
- Reset values: `mem_req_valid=0`, `out_valid=0`, `out_inst=0`, `out_pc=0`, `out_err=0`, FIFO empty, `drop=0`, state `IDLE`, `fetch_pc=RESET_PC`.
- First `mem_req_valid` one cycle after reset deasserts.
- Response at edge N → `out_valid` from cycle N+1 (registered FIFO, no bypass).
- Back-to-back: with zero-wait memory, one request per 3 cycles (IDLE→REQ→WAIT).
- `out_*` stable while `out_valid & !out_ready`.
- `out_valid` falls in cycle after redirect.
- Reset mid-transaction: all state cleared immediately; memory side must tolerate abandoned request.

## Configuration
- `YSYX_IFU_PERF_CNT_EN` defined: adds outputs `perf_fetch_cnt` (32, pushes of non-dropped beats), `perf_drop_cnt` (32, discarded beats), `perf_full_cyc` (32, cycles stalled in `IDLE` for no room); all reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package `ysyx_25030093_ifu_pkg`: state enum, `RESET_PC` default, FIFO entry struct {inst, pc, err}.
- One sub-module: `ysyx_25030093_ifu_fifo` (parametrised DEPTH/width sync FIFO with flush, count output).

## Test plan
- Reset release, memory ready=1, 1-cycle response → addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 in order; `out_pc` matches, `out_inst` matches returned data.
- `out_ready=0`, DEPTH=4 → exactly 4 entries pushed, no 5th `mem_req_valid`; release → all 4 drain, fetch resumes at 0x8000_0010.
- Redirect to 0x8000_0100 while in `WAIT` → stale beat discarded (`perf_drop_cnt=1`), next `out_pc=0x8000_0100`.
- Redirect while `mem_req_ready=0` in `REQ` → old addr held until accepted, its response dropped, next request addr 0x8000_0100.
- `mem_rsp_err=1` on 2nd fetch → `out_err=1` at `out_pc=0x8000_0004`, no further requests until redirect.
- Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
